jtmikie_sndlatch: RTL and testbench

Main-to-sound command path for the Mikie core: sits between the main CPU bus decoder and the sound board, whose `main_latch`/`m2s_on` inputs it drives. It buffers sound commands in a small FIFO so back-to-back writes are not lost. It presents the head command as the latch value and generates rising edges on `m2s_on`, which the sound board's IRQ flip-flop turns into Z80 interrupts. Re-triggering after each sound-CPU read is automatic while commands remain queued.

---
 rtl/jtmikie_sndlatch.sv | 152 +++++++++++++++
 tb/tb_jtmikie_sndlatch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtmikie_sndlatch.sv
// rtl/jtmikie_sndlatch.sv - main-to-sound command FIFO with auto re-triggered m2s_on pulses
// Head of the queue is presented as main_latch; each sound-CPU read re-arms the IRQ pulse.
module jtmikie_sndlatch #(
   parameter int AW        = 2,
   parameter int PULSE_LEN = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] cpu_dout,
   input  logic       latch_we,
   input  logic       trig_we,
   input  logic       trig_din,
   input  logic       snd_rd,
   output logic [7:0] main_latch,
   output logic       m2s_on,
   output logic       pending,
   output logic       full,
   output logic       ovf
);

   localparam int             DEPTH   = 2**AW;
   localparam int             PW      = $clog2(PULSE_LEN);
   localparam logic [AW:0]    CNT_MAX = (AW+1)'(DEPTH);
   localparam logic [PW-1:0]  PC_LAST = PW'(PULSE_LEN-1);

   typedef enum logic [1:0] {IDLE, FIRE, WAIT, GAP} state_t;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_cnt;
   logic [7:0]    r_last;
   logic          r_trg;
   state_t        r_state;
   logic [PW-1:0] r_pc;

   logic          w_full_now, w_empty, w_push, w_pop, w_drop, w_edge;
   logic [AW:0]   w_cnt_nxt;
   logic [AW-1:0] w_rd_nxt;
   logic [7:0]    w_head, w_latch_nxt;

   assign w_full_now = (r_cnt == CNT_MAX);
   assign w_empty    = (r_cnt == '0);
   assign w_pop      = snd_rd && !w_empty;
   // A full FIFO still accepts a push when a pop frees the slot in the same cycle
   assign w_push     = latch_we && (!w_full_now || snd_rd);
   assign w_drop     = latch_we && w_full_now && !snd_rd;
   assign w_edge     = trig_we && trig_din && !r_trg;
   assign w_rd_nxt   = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_push && !w_pop)
         w_cnt_nxt = r_cnt + (AW+1)'(1);
      else if (!w_push && w_pop)
         w_cnt_nxt = r_cnt - (AW+1)'(1);
   end

   // When the only entry after the update is the one being pushed, bypass the memory
   always_comb begin
      w_head = r_mem[w_rd_nxt];
      if (w_push && w_cnt_nxt == (AW+1)'(1))
         w_head = cpu_dout;
      w_latch_nxt = r_last;
      if (w_cnt_nxt != '0)
         w_latch_nxt = w_head;
      else if (w_pop)
         w_latch_nxt = r_mem[r_rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (!rst && w_push)
         r_mem[r_wr_ptr] <= cpu_dout;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_cnt      <= '0;
         r_last     <= 8'h00;
         r_trg      <= 1'b0;
         main_latch <= 8'h00;
         pending    <= 1'b0;
         full       <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)
            r_last <= r_mem[r_rd_ptr];
         if (w_drop)
            ovf <= 1'b1;
         if (trig_we)
            r_trg <= trig_din;
         r_rd_ptr   <= w_rd_nxt;
         r_cnt      <= w_cnt_nxt;
         main_latch <= w_latch_nxt;
         pending    <= (w_cnt_nxt != '0);
         full       <= (w_cnt_nxt == CNT_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_pc    <= '0;
         m2s_on  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               m2s_on <= 1'b0;
               if (w_edge) begin
                  r_state <= FIRE;
                  r_pc    <= '0;
                  m2s_on  <= 1'b1;
               end
            end
            FIRE: begin
               if (r_pc == PC_LAST) begin
                  r_state <= WAIT;
                  r_pc    <= '0;
                  m2s_on  <= 1'b0;
               end else begin
                  r_pc <= r_pc + PW'(1);
               end
            end
            WAIT: begin
               m2s_on <= 1'b0;
               if (snd_rd) begin
                  r_pc    <= '0;
                  r_state <= (w_cnt_nxt != '0) ? GAP : IDLE;
               end
            end
            GAP: begin
               if (r_pc == PC_LAST) begin
                  r_state <= FIRE;
                  r_pc    <= '0;
                  m2s_on  <= 1'b1;
               end else begin
                  r_pc <= r_pc + PW'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_pc    <= '0;
               m2s_on  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtmikie_sndlatch.sv
// tb/tb_jtmikie_sndlatch.sv - vector table plus directed pulse sequences for jtmikie_sndlatch
module tb_jtmikie_sndlatch;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] cpu_dout = 8'h00;
   logic       latch_we = 1'b0;
   logic       trig_we = 1'b0;
   logic       trig_din = 1'b0;
   logic       snd_rd = 1'b0;
   logic [7:0] main_latch;
   logic       m2s_on, pending, full, ovf;

   int checks = 0;
   int failures = 0;

   jtmikie_sndlatch #(.AW(2), .PULSE_LEN(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_dout   (cpu_dout),
      .latch_we   (latch_we),
      .trig_we    (trig_we),
      .trig_din   (trig_din),
      .snd_rd     (snd_rd),
      .main_latch (main_latch),
      .m2s_on     (m2s_on),
      .pending    (pending),
      .full       (full),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic       we;
      logic [7:0] din;
      logic       rd;
      logic [7:0] e_latch;
      logic       e_m2s;
      logic       e_pend;
      logic       e_full;
      logic       e_ovf;
   } vec_t;

   vec_t vecs [17];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; latch_we = 1'b0; trig_we = 1'b0; snd_rd = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      cpu_dout = d; latch_we = 1'b1;
      tick();
      latch_we = 1'b0;
   endtask

   task automatic pop();
      snd_rd = 1'b1;
      tick();
      snd_rd = 1'b0;
   endtask

   task automatic trig(input logic v);
      trig_din = v; trig_we = 1'b1;
      tick();
      trig_we = 1'b0;
   endtask

   task automatic high_len(output int n);
      n = 0;
      while (m2s_on && n < 50) begin
         n++;
         tick();
      end
   endtask

   task automatic low_len(output int n);
      n = 0;
      while (!m2s_on && n < 50) begin
         n++;
         tick();
      end
   endtask

   task automatic count_high(input int cycles, output int n);
      n = 0;
      for (int k = 0; k < cycles; k++) begin
         tick();
         if (m2s_on) n++;
      end
   endtask

   initial begin
      int n;
      //            rst   we    din     rd    latch   m2s   pend  full  ovf
      vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 8'hA1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 8'hA1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 8'hA1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 8'hA4, 1'b0, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 8'h55, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hA4, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[14] = '{1'b0, 1'b1, 8'h66, 1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

      tick();
      for (int i = 0; i < 17; i++) begin
         rst = vecs[i].rst; latch_we = vecs[i].we; cpu_dout = vecs[i].din; snd_rd = vecs[i].rd;
         tick();
         chk($sformatf("vec%0d_latch", i), main_latch, vecs[i].e_latch);
         chk($sformatf("vec%0d_m2s", i), {7'd0, m2s_on}, {7'd0, vecs[i].e_m2s});
         chk($sformatf("vec%0d_pending", i), {7'd0, pending}, {7'd0, vecs[i].e_pend});
         chk($sformatf("vec%0d_full", i), {7'd0, full}, {7'd0, vecs[i].e_full});
         chk($sformatf("vec%0d_ovf", i), {7'd0, ovf}, {7'd0, vecs[i].e_ovf});
      end
      rst = 1'b0; latch_we = 1'b0; snd_rd = 1'b0;

      // single command, one pulse, then re-arm from IDLE
      do_reset();
      push(8'h3C);
      chk("a_latch_after_push", main_latch, 8'h3C);
      trig(1'b1);
      chk("a_m2s_rise", {7'd0, m2s_on}, 8'd1);
      high_len(n);
      chk("a_pulse_len", n[7:0], 8'd8);
      chk("a_pending_wait", {7'd0, pending}, 8'd1);
      pop();
      chk("a_pending_after_rd", {7'd0, pending}, 8'd0);
      chk("a_latch_after_rd", main_latch, 8'h3C);
      count_high(12, n);
      chk("a_no_retrigger", n[7:0], 8'd0);
      trig(1'b0);
      trig(1'b1);
      chk("a_idle_rearm", {7'd0, m2s_on}, 8'd1);
      high_len(n);
      pop();

      // three queued commands, one trigger, automatic re-fire after each read
      do_reset();
      push(8'h11); push(8'h22); push(8'h33);
      chk("b_latch0", main_latch, 8'h11);
      trig(1'b1);
      high_len(n);
      chk("b_pulse1", n[7:0], 8'd8);
      tick(); tick();
      pop();
      chk("b_latch1", main_latch, 8'h22);
      low_len(n);
      chk("b_gap1", n[7:0], 8'd8);
      high_len(n);
      chk("b_pulse2", n[7:0], 8'd8);
      pop();
      chk("b_latch2", main_latch, 8'h33);
      low_len(n);
      chk("b_gap2", n[7:0], 8'd8);
      high_len(n);
      chk("b_pulse3", n[7:0], 8'd8);
      pop();
      chk("b_latch3", main_latch, 8'h33);
      chk("b_pending_end", {7'd0, pending}, 8'd0);
      count_high(20, n);
      chk("b_no_extra_pulse", n[7:0], 8'd0);

      // stale latch re-sent on empty FIFO; level-held trigger is not an edge
      do_reset();
      push(8'h7E);
      pop();
      chk("d_latch_stale", main_latch, 8'h7E);
      trig(1'b1);
      chk("d_m2s_rise", {7'd0, m2s_on}, 8'd1);
      high_len(n);
      chk("d_pulse_len", n[7:0], 8'd8);
      pop();
      chk("d_latch_after_rd", main_latch, 8'h7E);
      chk("d_pending", {7'd0, pending}, 8'd0);
      trig(1'b1);
      chk("d_no_edge_m2s", {7'd0, m2s_on}, 8'd0);
      count_high(12, n);
      chk("d_no_edge_pulse", n[7:0], 8'd0);
      push(8'h12);
      chk("d_ptr_ok", main_latch, 8'h12);

      // reset on the third cycle of a pulse
      do_reset();
      push(8'h01); push(8'h02);
      trig(1'b1);
      tick();
      rst = 1'b1;
      tick();
      chk("e_m2s_rst", {7'd0, m2s_on}, 8'd0);
      chk("e_pending_rst", {7'd0, pending}, 8'd0);
      chk("e_latch_rst", main_latch, 8'h00);
      rst = 1'b0;
      count_high(20, n);
      chk("e_no_pulse", n[7:0], 8'd0);
      trig(1'b1);
      chk("e_new_trigger", {7'd0, m2s_on}, 8'd1);
      high_len(n);
      pop();

      // pointer wrap with push/pop pairs
      do_reset();
      for (int i = 0; i < 10; i++) begin
         push(8'(i));
         chk($sformatf("f_latch%0d", i), main_latch, 8'(i));
         pop();
         chk($sformatf("f_pend%0d", i), {7'd0, pending}, 8'd0);
      end
      chk("f_ovf", {7'd0, ovf}, 8'd0);
      chk("f_latch_end", main_latch, 8'h09);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
